// File: rtl/vrf_seq.sv
// Vector register file element sequencer: streams vs1[i]/vs2[i] operand pairs to the
// execute unit under valid/ready and writes the in-order results back to vd[i].
module vrf_seq #(
   parameter int ELEMS = 8
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [4:0]  cmd_vs1,
   input  logic [4:0]  cmd_vs2,
   input  logic [4:0]  cmd_vd,
   input  logic [3:0]  cmd_vl,
   output logic        ram_re,
   output logic [7:0]  ram_raddr1,
   output logic [7:0]  ram_raddr2,
   input  logic [31:0] ram_rdataA,
   input  logic [31:0] ram_rdataB,
   output logic        ram_we,
   output logic [7:0]  ram_waddr,
   output logic [31:0] ram_wdata,
   output logic        op_valid,
   input  logic        op_ready,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic [2:0]  op_idx,
   input  logic        res_valid,
   input  logic [31:0] res_data,
   output logic        done,
   output logic        err
);

   localparam int         IW     = $clog2(ELEMS);
   localparam logic [3:0] VL_MAX = 4'(ELEMS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [4:0]  r_vs1;
   logic [4:0]  r_vs2;
   logic [4:0]  r_vd;
   logic [3:0]  r_vl;
   logic [3:0]  r_rcnt;
   logic [3:0]  r_wcnt;
   logic        r_op_valid;
   logic [2:0]  r_op_idx;
   logic        r_err;

   logic [3:0]  w_vl_clamp;
   logic        w_active;
   logic        w_issue;
   logic        w_we;
   logic [3:0]  w_wcnt_nxt;
   logic        w_op_valid_nxt;
   logic        w_complete;

   assign w_vl_clamp = (cmd_vl > VL_MAX) ? VL_MAX : cmd_vl;

   // NOTE: every signal written here gets a default first so no latch can be inferred.
   always_comb begin
      w_active       = (r_state == S_RUN) || (r_state == S_DRAIN);
      w_issue        = (r_state == S_RUN) && (r_rcnt < r_vl) && (!r_op_valid || op_ready);
      w_we           = w_active && res_valid && (r_wcnt < r_vl);
      w_wcnt_nxt     = r_wcnt + {3'b000, w_we};
      w_op_valid_nxt = r_op_valid;
      if (w_issue) begin
         w_op_valid_nxt = 1'b1;
      end else if (r_op_valid && op_ready) begin
         w_op_valid_nxt = 1'b0;
      end
      // Completion looks at the post-write count so done follows the final write directly.
      w_complete     = (r_rcnt == r_vl) && (w_wcnt_nxt == r_vl) && !r_op_valid;

      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_state_nxt = (w_vl_clamp != 4'd0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (w_complete) begin
               w_state_nxt = S_DONE;
            end else if (r_rcnt == r_vl) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_complete) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state    <= S_IDLE;
         r_vs1      <= '0;
         r_vs2      <= '0;
         r_vd       <= '0;
         r_vl       <= '0;
         r_rcnt     <= '0;
         r_wcnt     <= '0;
         r_op_valid <= 1'b0;
         r_op_idx   <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_op_valid <= w_op_valid_nxt;
         r_err      <= r_err | (res_valid && !w_we);
         if (r_state == S_IDLE) begin
            if (cmd_valid) begin
               r_vs1  <= cmd_vs1;
               r_vs2  <= cmd_vs2;
               r_vd   <= cmd_vd;
               r_vl   <= w_vl_clamp;
               r_rcnt <= '0;
               r_wcnt <= '0;
            end
         end else begin
            if (w_issue) begin
               r_rcnt   <= r_rcnt + 4'd1;
               r_op_idx <= r_rcnt[IW-1:0];
            end
            r_wcnt <= w_wcnt_nxt;
         end
      end
   end

   assign cmd_ready  = (r_state == S_IDLE);
   assign done       = (r_state == S_DONE);
   assign ram_re     = w_issue;
   assign ram_raddr1 = {r_vs1, r_rcnt[IW-1:0]};
   assign ram_raddr2 = {r_vs2, r_rcnt[IW-1:0]};
   assign ram_we     = w_we;
   assign ram_waddr  = {r_vd, r_wcnt[IW-1:0]};
   assign ram_wdata  = res_data;
   // The RAM holds its read data while ram_re is low, which keeps op_a/op_b stable on a stall.
   assign op_valid   = r_op_valid;
   assign op_idx     = r_op_idx;
   assign op_a       = ram_rdataA;
   assign op_b       = ram_rdataB;
   assign err        = r_err;

endmodule

// File: tb/tb_vrf_seq.sv
// Bench for vrf_seq: behavioural register-file RAM, 1-cycle execute unit and a scoreboard
// of expected operand pairs and RAM writes.
module tb_vrf_seq;

   logic        clk = 1'b0;
   logic        nrst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_vs1, cmd_vs2, cmd_vd;
   logic [3:0]  cmd_vl;
   logic        ram_re;
   logic [7:0]  ram_raddr1, ram_raddr2;
   logic [31:0] ram_rdataA, ram_rdataB;
   logic        ram_we;
   logic [7:0]  ram_waddr;
   logic [31:0] ram_wdata;
   logic        op_valid;
   logic        op_ready;
   logic [31:0] op_a, op_b;
   logic [2:0]  op_idx;
   logic        res_valid;
   logic [31:0] res_data;
   logic        done;
   logic        err;

   typedef struct packed {
      logic [2:0]  idx;
      logic [31:0] a;
      logic [31:0] b;
   } pair_t;

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   pair_t       pair_q[$];
   wr_t         wr_q[$];
   int          total = 0;
   int          bad = 0;
   int          reads = 0;
   int          writes = 0;
   bit          inc_mode = 1'b0;
   bit          loaded = 1'b0;
   logic [31:0] mem [256];
   logic [31:0] exp_mem [256];
   logic        add_v;
   logic [31:0] add_d;
   logic        inj_v;

   always #5 clk = ~clk;

   vrf_seq #(.ELEMS(8)) dut (
      .clk(clk), .nrst(nrst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd), .cmd_vl(cmd_vl),
      .ram_re(ram_re), .ram_raddr1(ram_raddr1), .ram_raddr2(ram_raddr2),
      .ram_rdataA(ram_rdataA), .ram_rdataB(ram_rdataB),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b), .op_idx(op_idx),
      .res_valid(res_valid), .res_data(res_data),
      .done(done), .err(err)
   );

   function automatic logic [31:0] f_init(input int i);
      logic [7:0] a;
      a = 8'(i);
      return {a, 8'h5a, ~a, 8'hc3};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Register file RAM: preloaded on the first edge, registered read ports reset to 0xdeaddead.
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= f_init(i);
         loaded <= 1'b1;
      end else if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
      end
   end

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ram_rdataA <= 32'hdeaddead;
         ram_rdataB <= 32'hdeaddead;
      end else if (ram_re) begin
         ram_rdataA <= mem[ram_raddr1];
         ram_rdataB <= mem[ram_raddr2];
      end
   end

   // Execute unit: one result per accepted pair, one cycle later.
   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         add_v <= 1'b0;
         add_d <= '0;
      end else begin
         add_v <= op_valid && op_ready;
         add_d <= inc_mode ? (op_a + 32'd1) : (op_a + op_b);
      end
   end

   assign res_valid = add_v | inj_v;
   assign res_data  = inj_v ? 32'h0bad0bad : add_d;

   // Scoreboard: every presented pair and every RAM write is compared against the queue head.
   always @(negedge clk) begin
      if (nrst) begin
         if (ram_re) reads++;
         if (op_valid) begin
            if (pair_q.size() == 0) begin
               total++;
               bad++;
               $error("FAIL op_unexpected observed=%0h expected=none", {op_idx, op_a, op_b});
            end else begin
               check("op_pair", 128'({op_idx, op_a, op_b}), 128'(pair_q[0]));
               if (op_ready) void'(pair_q.pop_front());
            end
         end
         if (ram_we) begin
            writes++;
            if (wr_q.size() == 0) begin
               total++;
               bad++;
               $error("FAIL write_unexpected observed=%0h expected=none", {ram_waddr, ram_wdata});
            end else begin
               check("ram_write", 128'({ram_waddr, ram_wdata}), 128'(wr_q[0]));
               void'(wr_q.pop_front());
            end
         end
      end
   end

   task automatic run_cmd(input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                          input logic [3:0] vl, input bit inc, input bit stall,
                          input int exp_done, input int abort_at);
      int          n;
      int          cyc;
      int          done_cyc;
      int          first_ov;
      logic [2:0]  i3;
      logic [31:0] a, b;
      wr_t         w;
      wr_t         pend[$];
      n = (vl > 4'd8) ? 8 : int'(vl);
      for (int i = 0; i < n; i++) begin
         i3 = 3'(i);
         a  = exp_mem[{vs1, i3}];
         b  = exp_mem[{vs2, i3}];
         pair_q.push_back('{idx: i3, a: a, b: b});
         w.addr = {vd, i3};
         w.data = inc ? (a + 32'd1) : (a + b);
         wr_q.push_back(w);
         pend.push_back(w);
      end
      foreach (pend[k]) exp_mem[pend[k].addr] = pend[k].data;
      inc_mode = inc;
      reads    = 0;
      writes   = 0;
      done_cyc = -1;
      first_ov = -1;

      @(negedge clk);
      cmd_vs1   = vs1;
      cmd_vs2   = vs2;
      cmd_vd    = vd;
      cmd_vl    = vl;
      cmd_valid = 1'b1;
      check_bit("cmd_ready_idle", cmd_ready, 1'b1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      cyc = 1;
      while (done_cyc < 0 && cyc < 200) begin
         if (cyc == abort_at) begin
            nrst = 1'b0;
            break;
         end
         op_ready = !(stall && cyc >= 3 && cyc <= 5);
         @(negedge clk);
         if (op_valid && first_ov < 0) first_ov = cyc;
         if (done) done_cyc = cyc;
         if (!op_ready) check_bit("stall_no_read", ram_re, 1'b0);
         @(posedge clk);
         #1 cyc++;
      end
      op_ready = 1'b1;

      if (abort_at == 0) begin
         check("done_cycle", 128'(done_cyc), 128'(exp_done));
         if (n > 0) check("first_op_cycle", 128'(first_ov), 128'(2));
         check("read_count", 128'(reads), 128'(n));
         check("write_count", 128'(writes), 128'(n));
         check("pairs_left", 128'(pair_q.size()), 128'(0));
         check("writes_left", 128'(wr_q.size()), 128'(0));
         @(negedge clk);
         check_bit("done_one_cycle", done, 1'b0);
         for (int i = 0; i < n; i++) begin
            i3 = 3'(i);
            check("ram_content", 128'(mem[{vd, i3}]), 128'(exp_mem[{vd, i3}]));
         end
      end else begin
         pair_q.delete();
         wr_q.delete();
      end
   endtask

   task automatic check_reset_outputs();
      check_bit("rst_cmd_ready", cmd_ready, 1'b1);
      check_bit("rst_op_valid", op_valid, 1'b0);
      check_bit("rst_ram_re", ram_re, 1'b0);
      check_bit("rst_ram_we", ram_we, 1'b0);
      check_bit("rst_done", done, 1'b0);
      check_bit("rst_err", err, 1'b0);
      check("rst_op_idx", 128'(op_idx), 128'(0));
      check("rst_raddr1", 128'(ram_raddr1), 128'(0));
      check("rst_raddr2", 128'(ram_raddr2), 128'(0));
      check("rst_waddr", 128'(ram_waddr), 128'(0));
      check("rst_op_a", 128'(op_a), 128'(32'hdeaddead));
      check("rst_op_b", 128'(op_b), 128'(32'hdeaddead));
   endtask

   initial begin
      nrst      = 1'b0;
      cmd_valid = 1'b0;
      cmd_vs1   = '0;
      cmd_vs2   = '0;
      cmd_vd    = '0;
      cmd_vl    = '0;
      op_ready  = 1'b1;
      inj_v     = 1'b0;
      for (int i = 0; i < 256; i++) exp_mem[i] = f_init(i);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      nrst = 1'b1;
      @(negedge clk);

      // Full-rate vl=8: done lands at cycle 11.
      run_cmd(5'd1, 5'd2, 5'd3, 4'd8, 1'b0, 1'b0, 11, 0);
      // op_ready low on cycles 3-5 pushes everything back by three cycles.
      run_cmd(5'd1, 5'd2, 5'd3, 4'd8, 1'b0, 1'b1, 14, 0);
      // vl=0 is a no-op that still pulses done.
      run_cmd(5'd1, 5'd2, 5'd3, 4'd0, 1'b0, 1'b0, 1, 0);
      // vl=12 clamps to 8; a ninth result is refused and flags err.
      run_cmd(5'd4, 5'd6, 5'd11, 4'd12, 1'b0, 1'b0, 11, 0);
      check_bit("err_before_extra", err, 1'b0);
      @(posedge clk);
      #1 inj_v = 1'b1;
      @(negedge clk);
      check_bit("extra_not_written", ram_we, 1'b0);
      @(posedge clk);
      #1 inj_v = 1'b0;
      @(negedge clk);
      check_bit("err_sticky_set", err, 1'b1);
      // vd overlaps vs1: each element incremented exactly once.
      run_cmd(5'd5, 5'd2, 5'd5, 4'd4, 1'b1, 1'b0, 7, 0);
      for (int i = 0; i < 4; i++) begin
         check("inplace_inc", 128'(mem[40 + i]), 128'(f_init(40 + i) + 32'd1));
      end
      check_bit("err_still_set", err, 1'b1);
      // Reset in cycle 5 abandons the command; element 0 already written stays.
      run_cmd(5'd6, 5'd7, 5'd9, 4'd8, 1'b0, 1'b0, 0, 5);
      #2;
      check_reset_outputs();
      check("keep_written", 128'(mem[72]), 128'(f_init(48) + f_init(56)));
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      run_cmd(5'd1, 5'd2, 5'd10, 4'd8, 1'b0, 1'b0, 11, 0);
      check_bit("err_after_rerun", err, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vrf_seq.md
# vrf_seq

Element sequencer for the vector register file RAM (256 x 32: 32 vector registers x 8 elements, two registered read ports, one write port). It accepts one vector-register command at a time and streams element operand pairs vs1[i], vs2[i] to the execute unit with valid/ready flow control. It writes the in-order results back to vd[i], then pulses done. It sits between the vector issue stage, the register file RAM and the vector ALU.

## Interface
Parameters:
- ELEMS, 8, elements per vector register; fixed by the RAM layout, index width 3.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_vs1, cmd_vs2, cmd_vd  in  5 each  source and destination register numbers.
- cmd_vl  in  4  element count. 0 = no-op. Values above 8 clamp to 8.
- ram_re  out  1  RAM read enable.
- ram_raddr1, ram_raddr2  out  8 each  {vs1, ridx} and {vs2, ridx}.
- ram_rdataA, ram_rdataB  in  32 each  RAM registered read data.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  8  {vd, widx}.
- ram_wdata  out  32  write data.
- op_valid  out  1  operand pair valid.
- op_ready  in  1  execute unit accepts the pair.
- op_a, op_b  out  32 each  equal to ram_rdataA and ram_rdataB, passed through.
- op_idx  out  3  element index of the current pair.
- res_valid  in  1  result valid. Always accepted; there is no res_ready.
- res_data  in  32  result.
- done  out  1  one-cycle pulse when the command completes.
- err  out  1  sticky flag for a stray or excess result.

## Operation
States:
- IDLE
  - cmd_ready=1.
  - On cmd_valid, latch vs1, vs2, vd and vl (clamped).
  - Clear ridx, widx, rcnt and wcnt.
  - Go to RUN if vl>0, otherwise go to DONE.
- RUN
  - Issue condition: rcnt<vl and (!op_valid or op_ready).
  - When the issue condition holds: ram_re=1 with addresses {vs1,rcnt[2:0]} and {vs2,rcnt[2:0]}, then increment rcnt.
  - op_valid is set on the cycle after a read is issued.
  - op_valid clears after an op_valid&&op_ready cycle in which no new read is issued.
  - op_idx is the index of the last issued read.
  - While stalled, ram_re=0, so the RAM holds rdata and op_a/op_b stay stable.
  - Go to DRAIN when rcnt reaches vl.
- DRAIN
  - No reads are issued.
  - Any remaining op_valid is held until it handshakes.
- Writes, in RUN and DRAIN
  - When res_valid and wcnt<vl: ram_we=1, ram_waddr={vd,wcnt[2:0]}, ram_wdata=res_data, then increment wcnt.
  - Write outputs are combinational from res_valid.
- Completion
  - When wcnt reaches vl and op_valid=0, go to DONE.
- DONE
  - done=1 for one cycle, then go to IDLE.

Rules:
- Overlap of vd with vs1 or vs2 is legal. Element i is always read before its result is written, so no hazard check is needed.
- A RAM cycle with a simultaneous read and write is legal and used.
- A res_valid seen in IDLE or DONE, or when wcnt==vl, causes no write and sets err. err clears only on reset.
- Counters rcnt and wcnt are 4 bits and never exceed vl, so no wrap-around occurs.

## Timing
Reset (async, nrst=0):
- State goes to IDLE; counters and latched fields go to 0.
- cmd_ready=1. op_valid, ram_re, ram_we, done and err are 0.
- op_idx=0. ram_raddr1, ram_raddr2 and ram_waddr are 0.
- op_a and op_b show the RAM reset value 0xdeaddead.

Latency (command accepted at cycle 0):
- First read issues at cycle 1.
- First op_valid at cycle 2.
- With op_ready held at 1, one pair per cycle; the last pair (vl=8) appears at cycle 9.
- For a result at cycle t, the RAM write lands at the cycle-t edge.
- done asserts the cycle after the final write, provided op_valid=0.
- vl=0: done at cycle 1, and no RAM access occurs.

Reset mid-command:
- Abandons the command immediately.
- Already-written elements stay in the RAM.

## Test plan
- vs1=1, vs2=2, vd=3, vl=8, op_ready=1, 1-cycle adder feeding res → RAM addresses 8..15 and 16..23 read, 24..31 written with the sums, done at cycle 11.
- Same command with op_ready low on cycles 3-5 → ram_re=0 and op_a/op_b held constant during the stall, no element skipped or duplicated, op_idx sequence 0..7.
- cmd_vl=0 → done at cycle 1, ram_re and ram_we never asserted.
- cmd_vl=12 → exactly 8 reads and 8 writes; a 9th res_valid is not written and sets err=1.
- vd=vs1=5, vl=4, result = op_a+1 → elements 40..43 each incremented exactly once.
- nrst pulsed low at cycle 5 mid-command → all outputs at reset values, cmd_ready=1, and the next command runs normally.
